// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit path.
//   arb_state_t : state of the TX port arbiter (idle / locked to one owner)
//   UART_BYTE_W : width of one UART payload byte
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage : uart_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin priority encoder. Returns the first set
// bit of req, searching ptr, ptr+1, ... modulo N_REQ.
// Ports:
//   req  in  N_REQ  request vector
//   ptr  in  IDX_W  index with highest priority
//   idx  out IDX_W  chosen index (equals ptr when nothing is requested)
//   any  out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk the search order from the lowest priority to the highest, so the
    // last match written (the one closest to ptr) is the winner.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] pos_idx;
        pos     = 0;
        pos_idx = '0;
        idx     = ptr;
        any     = |req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos     = (int'(ptr) + k) % N_REQ;
            pos_idx = IDX_W'(pos);
            if (req[pos_idx]) begin
                idx = pos_idx;
            end
        end
    end

endmodule : rr_pick

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter sharing one UART TX byte port between N_REQ requesters.
// The grant is locked to one requester for a whole message (ended by a byte
// with req_last set) so text never interleaves. A watchdog frees a lock whose
// owner stops offering bytes for IDLE_MAX consecutive cycles.
// Ports:
//   clk        in  1          system clock
//   rst_n      in  1          synchronous reset, active-low
//   req_valid  in  N_REQ      per-requester byte valid
//   req_last   in  N_REQ      byte is the last of its message
//   req_data   in  N_REQ*8    requester i byte at [8i+7:8i]
//   req_ready  out N_REQ      per-requester accept (one-hot or zero)
//   out_valid  out 1          byte valid toward the UART controller
//   out_ready  in  1          UART controller accept
//   out_data   out 8          byte toward the UART controller
//   grant_id   out IDX_W      current or last owner
//   busy       out 1          locked or holding a byte
//   timeout    out 1          one-cycle pulse on watchdog release
// -----------------------------------------------------------------------------
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int IDLE_MAX = 1024,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_last,
    input  logic [N_REQ*UART_BYTE_W-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [UART_BYTE_W-1:0]       out_data,
    output logic [IDX_W-1:0]             grant_id,
    output logic                         busy,
    output logic                         timeout
);

    localparam int WD_W = $clog2(IDLE_MAX + 1);

    arb_state_t             state, state_next;
    logic [IDX_W-1:0]       rr_ptr, rr_next;
    logic [IDX_W-1:0]       grant_next;
    logic [WD_W-1:0]        wdog, wdog_next;
    logic                   timeout_next;

    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   out_free;
    logic                   owner_valid;
    logic                   owner_last;
    logic [UART_BYTE_W-1:0] owner_data;
    logic                   in_xfer;
    logic [IDX_W-1:0]       owner_inc;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // The owner's view of the requester bus, plus whether the one-entry output
    // register can take a byte this cycle (empty, or being drained right now).
    always_comb begin
        out_free    = !out_valid || out_ready;
        owner_valid = req_valid[grant_id];
        owner_last  = req_last[grant_id];
        owner_data  = req_data[grant_id*UART_BYTE_W +: UART_BYTE_W];
        owner_inc   = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        req_ready   = '0;
        if (state == ARB_LOCK && out_free) begin
            req_ready = N_REQ'(1) << grant_id;
        end
        in_xfer = (state == ARB_LOCK) && owner_valid && out_free;
        busy    = (state == ARB_LOCK) || out_valid;
    end

    // Next-state logic. Back-pressure on the output keeps owner_valid high, so
    // it clears the watchdog rather than counting as an idle owner.
    always_comb begin
        state_next   = state;
        grant_next   = grant_id;
        rr_next      = rr_ptr;
        wdog_next    = wdog;
        timeout_next = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_next = ARB_LOCK;
                    grant_next = pick_idx;
                    wdog_next  = '0;
                end
            end
            ARB_LOCK: begin
                if (owner_valid) begin
                    wdog_next = '0;
                    if (in_xfer && owner_last) begin
                        state_next = ARB_IDLE;
                        rr_next    = owner_inc;
                    end
                end else begin
                    if (wdog != WD_W'(IDLE_MAX)) begin
                        wdog_next = wdog + 1'b1;
                    end
                    if (wdog >= WD_W'(IDLE_MAX - 1)) begin
                        state_next   = ARB_IDLE;
                        rr_next      = owner_inc;
                        timeout_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Arbiter state register: FSM state, owner, round-robin pointer, watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            wdog     <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
            rr_ptr   <= rr_next;
            wdog     <= wdog_next;
            timeout  <= timeout_next;
        end
    end

    // One-entry output register. A load and a drain in the same cycle simply
    // reload, which is what gives one byte per cycle under steady out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= owner_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : uart_tx_arb

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
// Directed bench for uart_tx_arb (N_REQ=4, IDLE_MAX=8). Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    uart_tx_arb #(
        .N_REQ    (4),
        .IDLE_MAX (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last,
                                 input logic ordy);
        req_valid = valid;
        req_last  = last;
        out_ready = ordy;
    endtask

    task automatic setByte(input int i, input logic [7:0] val);
        req_data[i*8 +: 8] = val;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [1:0] order [4];
        logic [7:0] base;
        order[0] = 2'd3;
        order[1] = 2'd0;
        order[2] = 2'd1;
        order[3] = 2'd2;

        // ---------------- reset state ----------------
        rst_n    = 1'b0;
        req_data = '0;
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        tick();
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_data",  out_data,  8'h00);
        checkOutput("rst_req_ready", req_ready, 4'b0000);
        checkOutput("rst_grant_id",  grant_id,  2'd0);
        checkOutput("rst_busy",      busy,      1'b0);
        checkOutput("rst_timeout",   timeout,   1'b0);

        // ---------------- single message from requester 2 ----------------
        rst_n = 1'b1;
        setByte(2, 8'h48);
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        tick();
        checkOutput("single_grant",     grant_id,  2'd2);
        checkOutput("single_ready",     req_ready, 4'b0100);
        checkOutput("single_busy",      busy,      1'b1);
        checkOutput("single_nobyte",    out_valid, 1'b0);
        tick();
        checkOutput("single_b0_valid",  out_valid, 1'b1);
        checkOutput("single_b0_data",   out_data,  8'h48);
        setByte(2, 8'h69);
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        tick();
        checkOutput("single_b1_data",   out_data,  8'h69);
        checkOutput("single_b1_valid",  out_valid, 1'b1);
        checkOutput("single_idle_rdy",  req_ready, 4'b0000);
        checkOutput("single_busy_out",  busy,      1'b1);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        checkOutput("single_drained",   out_valid, 1'b0);
        checkOutput("single_not_busy",  busy,      1'b0);

        // ---------------- wrap and fairness (pointer now 3) ----------------
        for (int i = 0; i < 4; i++) setByte(i, 8'hA0 + 8'(i));
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        for (int n = 0; n < 4; n++) begin
            tick();
            checkOutput($sformatf("wrap_grant%0d", n), grant_id, order[n]);
            checkOutput($sformatf("wrap_ready%0d", n), req_ready, 4'b0001 << order[n]);
            tick();
            checkOutput($sformatf("wrap_data%0d", n), out_data, 8'hA0 + 8'(order[n]));
            req_valid[order[n]] = 1'b0;
        end
        tick();
        checkOutput("wrap_drained", out_valid, 1'b0);

        // ---------------- back-pressure (pointer 3, requester 1) ----------------
        setByte(1, 8'h31);
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        tick();
        checkOutput("bp_grant", grant_id, 2'd1);
        tick();
        checkOutput("bp_b0", out_data, 8'h31);
        setByte(1, 8'h32);
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        for (int n = 0; n < 20; n++) begin
            tick();
            checkOutput("bp_hold_valid", out_valid, 1'b1);
            checkOutput("bp_hold_data",  out_data,  8'h31);
            checkOutput("bp_hold_ready", req_ready, 4'b0000);
            checkOutput("bp_no_timeout", timeout,   1'b0);
        end
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        tick();
        checkOutput("bp_b1", out_data, 8'h32);
        setByte(1, 8'h33);
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        tick();
        checkOutput("bp_b2", out_data, 8'h33);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        checkOutput("bp_drained", out_valid, 1'b0);
        checkOutput("bp_idle",    busy,      1'b0);

        // ---------------- watchdog (pointer 2, owner 1 stalls) ----------------
        setByte(1, 8'h10);
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        tick();
        checkOutput("wd_grant", grant_id, 2'd1);
        tick();
        checkOutput("wd_b0", out_data, 8'h10);
        setByte(2, 8'h20);
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        for (int n = 1; n < 8; n++) begin
            tick();
            checkOutput($sformatf("wd_wait%0d_timeout", n), timeout,   1'b0);
            checkOutput($sformatf("wd_wait%0d_busy", n),    busy,      1'b1);
            checkOutput($sformatf("wd_wait%0d_ready", n),   req_ready, 4'b0010);
        end
        tick();
        checkOutput("wd_timeout_pulse", timeout,   1'b1);
        checkOutput("wd_released",      busy,      1'b0);
        checkOutput("wd_released_rdy",  req_ready, 4'b0000);
        tick();
        checkOutput("wd_pulse_once",    timeout,   1'b0);
        checkOutput("wd_next_grant",    grant_id,  2'd2);
        tick();
        checkOutput("wd_next_data",     out_data,  8'h20);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        tick();

        // ---------------- reset mid-message (pointer 3, requester 3) ----------------
        setByte(3, 8'h55);
        applyStimulus(4'b1000, 4'b0000, 1'b1);
        tick();
        checkOutput("rm_grant", grant_id, 2'd3);
        tick();
        checkOutput("rm_valid", out_valid, 1'b1);
        setByte(3, 8'h56);
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        rst_n = 1'b0;
        tick();
        checkOutput("rm_out_valid", out_valid, 1'b0);
        checkOutput("rm_req_ready", req_ready, 4'b0000);
        checkOutput("rm_grant_id",  grant_id,  2'd0);
        checkOutput("rm_busy",      busy,      1'b0);
        rst_n = 1'b1;
        setByte(1, 8'h71);
        setByte(3, 8'h73);
        applyStimulus(4'b1010, 4'b1010, 1'b1);
        tick();
        checkOutput("rm_first_grant", grant_id, 2'd1);
        tick();
        checkOutput("rm_first_data", out_data, 8'h71);
        applyStimulus(4'b1000, 4'b1000, 1'b1);
        tick();
        checkOutput("rm_second_grant", grant_id, 2'd3);
        tick();
        checkOutput("rm_second_data", out_data, 8'h73);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        tick();

        // ---------------- no interleave (pointer 0, requesters 0 and 1) ----------------
        setByte(0, 8'h41);
        setByte(1, 8'h61);
        applyStimulus(4'b0011, 4'b0000, 1'b1);
        for (int r = 0; r < 2; r++) begin
            base = (r == 0) ? 8'h41 : 8'h61;
            tick();
            checkOutput($sformatf("ni_grant%0d", r), grant_id,  2'(r));
            checkOutput($sformatf("ni_ready%0d", r), req_ready, 4'b0001 << r);
            checkOutput($sformatf("ni_empty%0d", r), out_valid, 1'b0);
            for (int b = 0; b < 3; b++) begin
                tick();
                checkOutput($sformatf("ni_r%0d_b%0d_data", r, b),  out_data,  base + 8'(b));
                checkOutput($sformatf("ni_r%0d_b%0d_valid", r, b), out_valid, 1'b1);
                if (b < 2) begin
                    checkOutput($sformatf("ni_r%0d_b%0d_ready", r, b), req_ready, 4'b0001 << r);
                    setByte(r, base + 8'(b + 1));
                    req_last[r] = (b == 1);
                end else begin
                    checkOutput($sformatf("ni_r%0d_release", r), req_ready, 4'b0000);
                    req_valid[r] = 1'b0;
                    req_last[r]  = 1'b0;
                end
            end
        end
        tick();
        checkOutput("ni_drained", out_valid, 1'b0);
        checkOutput("ni_idle",    busy,      1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_arb
